palette_update_ctrl: RTL

Run-time palette controller for the VGA pixel path. It holds a writable shadow palette that a host fills through a valid/ready port, plus an active palette that drives pixel color lookup. On a host commit it copies the shadow into the active palette one entry per cycle, starting at the next rising edge of vertical blanking, so a palette change never tears a visible frame. It replaces the fixed ROM lookup when a design needs palette changes at run time.

---
 rtl/palette_update_ctrl_pkg.sv | 31 +++
 rtl/palette_update_ctrl_bank.sv | 32 +++
 rtl/palette_update_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/palette_update_ctrl_pkg.sv
// Shared types and helpers for the run-time palette controller.
package palette_update_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_640X480X1BPPX60HZ = 2'd0,
    MODE_640X480X2BPPX60HZ = 2'd1,
    MODE_640X480X3BPPX60HZ = 2'd2,
    MODE_640X480X4BPPX60HZ = 2'd3
  } video_mode_e;

  localparam int PALETTE_COLOR_BIT_SIZE = 12;

  typedef enum logic [1:0] {
    PAL_CTRL_IDLE  = 2'd0,
    PAL_CTRL_ARMED = 2'd1,
    PAL_CTRL_COPY  = 2'd2,
    PAL_CTRL_DONE  = 2'd3
  } pal_ctrl_state_e;

  // Bits per pixel for a video mode; the 4 bpp mode exists but is not
  // supported by the palette controller.
  function automatic int GET_BPP(input video_mode_e mode);
    case (mode)
      MODE_640X480X1BPPX60HZ: return 1;
      MODE_640X480X2BPPX60HZ: return 2;
      MODE_640X480X3BPPX60HZ: return 3;
      default:                return 4;
    endcase
  endfunction

endpackage

// File: rtl/palette_update_ctrl_bank.sv
// Palette register file: async clear, one synchronous write port and one
// combinational read port. Used for both the shadow and the active palette.
module palette_update_ctrl_bank #(
  parameter int AW    = 3,
  parameter int W     = 12,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage: cleared on reset, one entry written per enabled clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/palette_update_ctrl.sv
// Run-time palette controller: host fills a shadow palette, a commit copies
// it into the active palette one entry per cycle starting at the next
// vblank rising edge so a visible frame never tears.
//
// state | meaning
// IDLE  | host writes accepted, waiting for commit
// ARMED | commit taken, waiting for a vblank rising edge
// COPY  | active[idx] <= shadow[idx], one entry per cycle
// DONE  | one-cycle completion pulse
module palette_update_ctrl
  import palette_update_ctrl_pkg::*;
#(
  parameter video_mode_e MODE    = MODE_640X480X3BPPX60HZ,
  parameter int          COLOR_W = PALETTE_COLOR_BIT_SIZE,
  localparam int         BPP     = GET_BPP(MODE),
  localparam int         N       = 2 ** BPP
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               vblank_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [BPP-1:0]     wr_index_i,
  input  logic [COLOR_W-1:0] wr_color_i,
  input  logic               commit_i,
  output logic               commit_pending_o,
  output logic               busy_o,
  output logic               done_o,
  input  logic [BPP-1:0]     color_select_i,
  output logic [COLOR_W-1:0] color_o
);

  // One spare bit so the index cannot wrap before the terminal compare.
  localparam int             IDX_W    = BPP + 1;
  localparam logic [BPP:0]   IDX_LAST = IDX_W'(N - 1);

  if (BPP < 1 || BPP > 3) begin : g_bpp_check
    $error("palette_update_ctrl: unsupported bits per pixel %0d (must be 1..3)", BPP);
  end

  pal_ctrl_state_e      state;
  logic [BPP:0]         copy_idx;
  logic                 vblank_q;
  logic                 vblank_rise;
  logic                 shadow_wr;
  logic                 active_wr;
  logic [COLOR_W-1:0]   shadow_rd;

  assign vblank_rise = vblank_i & ~vblank_q;
  assign shadow_wr   = wr_valid_i & wr_ready_o;
  assign active_wr   = (state == PAL_CTRL_COPY);

  palette_update_ctrl_bank #(
    .AW (BPP),
    .W  (COLOR_W)
  ) u_shadow (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (shadow_wr),
    .wr_addr (wr_index_i),
    .wr_data (wr_color_i),
    .rd_addr (copy_idx[BPP-1:0]),
    .rd_data (shadow_rd)
  );

  palette_update_ctrl_bank #(
    .AW (BPP),
    .W  (COLOR_W)
  ) u_active (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (active_wr),
    .wr_addr (copy_idx[BPP-1:0]),
    .wr_data (shadow_rd),
    .rd_addr (color_select_i),
    .rd_data (color_o)
  );

  // Commit sequencing with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= PAL_CTRL_IDLE;
      copy_idx         <= '0;
      vblank_q         <= 1'b0;
      wr_ready_o       <= 1'b1;
      commit_pending_o <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      vblank_q <= vblank_i;
      done_o   <= 1'b0;
      case (state)
        PAL_CTRL_IDLE: begin
          if (commit_i) begin
            state            <= PAL_CTRL_ARMED;
            wr_ready_o       <= 1'b0;
            commit_pending_o <= 1'b1;
          end
        end
        PAL_CTRL_ARMED: begin
          if (vblank_rise) begin
            state    <= PAL_CTRL_COPY;
            copy_idx <= '0;
            busy_o   <= 1'b1;
          end
        end
        PAL_CTRL_COPY: begin
          copy_idx <= copy_idx + 1'b1;
          if (copy_idx == IDX_LAST) begin
            state            <= PAL_CTRL_DONE;
            busy_o           <= 1'b0;
            commit_pending_o <= 1'b0;
            done_o           <= 1'b1;
          end
        end
        PAL_CTRL_DONE: begin
          state      <= PAL_CTRL_IDLE;
          wr_ready_o <= 1'b1;
        end
        default: begin
          state            <= PAL_CTRL_IDLE;
          wr_ready_o       <= 1'b1;
          commit_pending_o <= 1'b0;
          busy_o           <= 1'b0;
        end
      endcase
    end
  end

endmodule
